// File: rtl/peridot_romdata_pkg.sv
// Shared constants, FSM encoding and decode helpers for the PERIDOT board serial-ROM image.
package peridot_romdata_pkg;

    localparam int ROM_HDR_LEN = 10;
    localparam int ROM_UID_LEN = 16;
    localparam int ROM_TOTAL   = ROM_HDR_LEN + ROM_UID_LEN;
    localparam logic [7:0] ROM_VERSION = 8'h02;

    localparam logic [4:0] GENCODE_ADDR   = 5'd7;
    localparam logic [4:0] UID_FIRST_ADDR = 5'(ROM_HDR_LEN);
    localparam logic [4:0] LAST_ADDR      = 5'(ROM_TOTAL - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAITRDY,
        ST_FETCH,
        ST_PUSH,
        ST_DONE
    } state_t;

    // Header signature "J7W",ver,"J72",gen,"93". The gencode slot returns 0 because it is
    // checked separately against the EXPECT_GENCODE parameter.
    function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h4a;  // 'J'
            4'd1:    b = 8'h37;  // '7'
            4'd2:    b = 8'h57;  // 'W'
            4'd3:    b = ROM_VERSION;
            4'd4:    b = 8'h4a;  // 'J'
            4'd5:    b = 8'h37;  // '7'
            4'd6:    b = 8'h32;  // '2'
            4'd8:    b = 8'h39;  // '9'
            4'd9:    b = 8'h33;  // '3'
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // ASCII hex character to {ok, nibble}; non-hex characters give ok=0 and nibble 0.
    function automatic logic [4:0] hex2nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'h00;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h41 && c <= 8'h46)
            r = {1'b1, 4'(c - 8'h37)};
        else if (c >= 8'h61 && c <= 8'h66)
            r = {1'b1, 4'(c - 8'h57)};
        return r;
    endfunction

endpackage

// File: rtl/peridot_romreader_hexdec.sv
// Combinational ASCII-hex character decoder for the UID section of the ROM image.
module peridot_romreader_hexdec
    import peridot_romdata_pkg::*;
(
    input  logic [7:0] ascii,
    output logic       ok,
    output logic [3:0] nibble
);

    assign {ok, nibble} = hex2nibble(ascii);

endmodule

// File: rtl/peridot_board_romreader.sv
// PERIDOT serial-ROM reader: walks the 26-byte image, validates the header, rebuilds the
// 64-bit UID and optionally forwards every raw byte on a valid/ready stream.
module peridot_board_romreader
    import peridot_romdata_pkg::*;
#(
    parameter logic [7:0] EXPECT_GENCODE = 8'h00,
    parameter int          STREAM_ENABLE  = 1,
    parameter int          READY_TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        rom_ready,
    output logic [4:0]  rom_byteaddr,
    input  logic [7:0]  rom_bytedata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [7:0]  gencode,
    output logic [63:0] uid,
    output logic        uid_valid,
    output logic        err_sig,
    output logic        err_hex,
    output logic        err_timeout
);

    localparam int CNT_W = $clog2(READY_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(READY_TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       data_reg;
    logic             hex_ok;
    logic [3:0]       hex_nibble;
    logic             hdr_miss;

    peridot_romreader_hexdec u_hexdec (
        .ascii  (rom_bytedata),
        .ok     (hex_ok),
        .nibble (hex_nibble)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    // NOTE: defaulting state_nxt first keeps this block purely combinational (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_WAITRDY;
            ST_WAITRDY: begin
                if (rom_ready)            state_nxt = ST_FETCH;
                else if (cnt == CNT_MAX)  state_nxt = ST_DONE;
            end
            ST_FETCH: begin
                if (STREAM_ENABLE != 0)               state_nxt = ST_PUSH;
                else if (rom_byteaddr == LAST_ADDR)   state_nxt = ST_DONE;
            end
            ST_PUSH: begin
                if (out_ready) state_nxt = (rom_byteaddr == LAST_ADDR) ? ST_DONE : ST_FETCH;
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // FSM-derived outputs; the stream side only exists when STREAM_ENABLE is set.
    always_comb begin
        busy      = (state == ST_WAITRDY) || (state == ST_FETCH) || (state == ST_PUSH);
        done      = (state == ST_DONE);
        out_valid = (STREAM_ENABLE != 0) && (state == ST_PUSH);
        out_sop   = out_valid && (rom_byteaddr == 5'd0);
        out_eop   = out_valid && (rom_byteaddr == LAST_ADDR);
        out_data  = data_reg;
    end

    // Header comparison for the byte currently on the ROM bus.
    always_comb begin
        hdr_miss = 1'b0;
        if (rom_byteaddr == GENCODE_ADDR)
            hdr_miss = (EXPECT_GENCODE != 8'h00) && (rom_bytedata != EXPECT_GENCODE);
        else
            hdr_miss = (rom_bytedata != hdr_byte(rom_byteaddr[3:0]));
    end

    // Address, timeout counter, byte capture, UID assembly and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_byteaddr <= 5'd0;
            cnt          <= '0;
            data_reg     <= 8'h00;
            gencode      <= 8'h00;
            uid          <= 64'h0;
            uid_valid    <= 1'b0;
            err_sig      <= 1'b0;
            err_hex      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rom_byteaddr <= 5'd0;
                        cnt          <= '0;
                        uid          <= 64'h0;
                        uid_valid    <= 1'b0;
                        err_sig      <= 1'b0;
                        err_hex      <= 1'b0;
                        err_timeout  <= 1'b0;
                    end
                end
                ST_WAITRDY: begin
                    if (!rom_ready) begin
                        if (cnt == CNT_MAX) err_timeout <= 1'b1;
                        else                cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_FETCH: begin
                    data_reg <= rom_bytedata;
                    if (rom_byteaddr < UID_FIRST_ADDR) begin
                        if (hdr_miss) err_sig <= 1'b1;
                        if (rom_byteaddr == GENCODE_ADDR) gencode <= rom_bytedata;
                    end else begin
                        uid <= {uid[59:0], hex_nibble};
                        if (!hex_ok) err_hex <= 1'b1;
                    end
                    // Without a stream the FETCH state walks the address on its own.
                    if (STREAM_ENABLE == 0 && rom_byteaddr != LAST_ADDR)
                        rom_byteaddr <= rom_byteaddr + 5'd1;
                end
                ST_PUSH: begin
                    if (out_ready && rom_byteaddr != LAST_ADDR)
                        rom_byteaddr <= rom_byteaddr + 5'd1;
                end
                ST_DONE: uid_valid <= ~(err_sig | err_hex | err_timeout);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_peridot_board_romreader.sv
// Self-checking bench: three reader instances (default, EXPECT_GENCODE=0x41, no stream)
// share one ROM image and are checked against a byte-list/UID model every cycle.
`timescale 1ns/1ps
module tb_peridot_board_romreader;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, rom_ready, out_ready;
    logic bp_mode = 1'b0;
    logic bp_rnd  = 1'b1;
    logic [7:0] rom_img [26];

    logic        busy_v [N], done_v [N], ov_v [N], sop_v [N], eop_v [N];
    logic        uidv_v [N], es_v [N], eh_v [N], et_v [N];
    logic [4:0]  addr_v [N];
    logic [7:0]  rd_v [N], od_v [N], gen_v [N];
    logic [63:0] uid_v [N];

    assign out_ready = bp_mode ? bp_rnd : 1'b1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam logic [7:0] EXP = (g == 1) ? 8'h41 : 8'h00;
        localparam int SE = (g == 2) ? 0 : 1;
        assign rd_v[g] = (addr_v[g] < 5'd26) ? rom_img[addr_v[g]] : 8'h00;
        peridot_board_romreader #(
            .EXPECT_GENCODE (EXP),
            .STREAM_ENABLE  (SE),
            .READY_TIMEOUT  (15)
        ) dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start),
            .busy         (busy_v[g]),
            .done         (done_v[g]),
            .rom_ready    (rom_ready),
            .rom_byteaddr (addr_v[g]),
            .rom_bytedata (rd_v[g]),
            .out_valid    (ov_v[g]),
            .out_ready    (out_ready),
            .out_data     (od_v[g]),
            .out_sop      (sop_v[g]),
            .out_eop      (eop_v[g]),
            .gencode      (gen_v[g]),
            .uid          (uid_v[g]),
            .uid_valid    (uidv_v[g]),
            .err_sig      (es_v[g]),
            .err_hex      (eh_v[g]),
            .err_timeout  (et_v[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h, required 0x%0h", name, g, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          exp_sig [N];
    bit          exp_hex, exp_to;
    logic [63:0] exp_uid;
    bit          chk_lat = 1'b1;

    function automatic logic [7:0] exp_gen(input int g);
        return (g == 1) ? 8'h41 : 8'h00;
    endfunction

    function automatic logic [4:0] ref_hex(input logic [7:0] ch);
        string digits = "0123456789ABCDEF";
        logic [7:0] up = ch;
        if (ch >= "a" && ch <= "z") up = ch - 8'd32;
        for (int i = 0; i < 16; i++)
            if (digits[i] == up) return {1'b1, 4'(i)};
        return 5'h00;
    endfunction

    task automatic compute_model();
        string hs = "J7W J72 93";
        bit miss = 1'b0;
        logic [4:0] r;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                if (rom_img[i] != 8'h02) miss = 1'b1;
            end else if (i != 7) begin
                if (rom_img[i] != hs[i]) miss = 1'b1;
            end
        end
        exp_hex = 1'b0;
        exp_uid = 64'h0;
        for (int i = 10; i < 26; i++) begin
            r = ref_hex(rom_img[i]);
            exp_uid = exp_uid * 16 + 64'(r[3:0]);
            if (!r[4]) exp_hex = 1'b1;
        end
        exp_to = !rom_ready;
        for (int g = 0; g < N; g++)
            exp_sig[g] = !exp_to && (miss || (exp_gen(g) != 8'h00 && rom_img[7] != exp_gen(g)));
        if (exp_to) begin
            exp_hex = 1'b0;
            exp_uid = 64'h0;
        end
    endtask

    function automatic int exp_cnt(input int g);
        return (exp_to || g == 2) ? 0 : 26;
    endfunction

    function automatic int exp_lat(input int g);
        if (exp_to) return 17;
        return (g == 2) ? 28 : 54;
    endfunction

    // ---------------- compare process ----------------
    bit         active [N];
    bit         hold [N];
    bit         chk_uv [N];
    int         cyc [N];
    int         idx [N];
    int         ndone [N];
    logic [7:0] held [N];

    always @(negedge clk) begin
        if (reset) begin
            for (int g = 0; g < N; g++) begin
                active[g] = 1'b0;
                hold[g]   = 1'b0;
                chk_uv[g] = 1'b0;
            end
        end else begin
            for (int g = 0; g < N; g++) begin
                if (chk_uv[g]) begin
                    check("uid_valid", g, uidv_v[g], !(exp_sig[g] || exp_hex || exp_to));
                    chk_uv[g] = 1'b0;
                end
                if (active[g]) begin
                    cyc[g]++;
                    if (hold[g]) begin
                        check("hold_valid", g, ov_v[g], 1);
                        check("hold_data", g, od_v[g], held[g]);
                    end
                    if (ov_v[g] && out_ready) begin
                        if (idx[g] < 26) begin
                            check("data", g, od_v[g], rom_img[idx[g]]);
                            check("sop", g, sop_v[g], idx[g] == 0);
                            check("eop", g, eop_v[g], idx[g] == 25);
                        end else begin
                            check("extra_byte", g, idx[g], 25);
                        end
                        idx[g]++;
                    end
                    hold[g] = ov_v[g] && !out_ready;
                    held[g] = od_v[g];
                    if (done_v[g]) begin
                        ndone[g]++;
                        check("busy_at_done", g, busy_v[g], 0);
                        check("err_sig", g, es_v[g], exp_sig[g]);
                        check("err_hex", g, eh_v[g], exp_hex);
                        check("err_timeout", g, et_v[g], exp_to);
                        check("uid", g, uid_v[g], exp_uid);
                        check("uid_valid_at_done", g, uidv_v[g], 0);
                        check("byte_count", g, idx[g], exp_cnt(g));
                        if (!exp_to) check("gencode", g, gen_v[g], rom_img[7]);
                        if (chk_lat) check("latency", g, cyc[g], exp_lat(g));
                        active[g] = 1'b0;
                        chk_uv[g] = 1'b1;
                    end else begin
                        check("busy", g, busy_v[g], 1);
                    end
                end else if (done_v[g]) begin
                    ndone[g]++;
                    check("stray_done", g, done_v[g], 0);
                end
                if (start && !active[g]) begin
                    active[g] = 1'b1;
                    cyc[g]    = 0;
                    idx[g]    = 0;
                    hold[g]   = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bp_rnd = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_rom(input logic [7:0] gen, input string u);
        rom_img[0] = 8'h4a; rom_img[1] = 8'h37; rom_img[2] = 8'h57; rom_img[3] = 8'h02;
        rom_img[4] = 8'h4a; rom_img[5] = 8'h37; rom_img[6] = 8'h32; rom_img[7] = gen;
        rom_img[8] = 8'h39; rom_img[9] = 8'h33;
        for (int i = 0; i < 16; i++) rom_img[10 + i] = u[i];
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((active[0] || active[1] || active[2]) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
        tick();
        tick();
    endtask

    task automatic run_read(input int budget);
        compute_model();
        pulse_start();
        wait_idle(budget);
    endtask

    task automatic check_reset_all();
        for (int g = 0; g < N; g++) begin
            check("rst_busy", g, busy_v[g], 0);
            check("rst_done", g, done_v[g], 0);
            check("rst_valid", g, ov_v[g], 0);
            check("rst_sop", g, sop_v[g], 0);
            check("rst_eop", g, eop_v[g], 0);
            check("rst_data", g, od_v[g], 0);
            check("rst_addr", g, addr_v[g], 0);
            check("rst_gencode", g, gen_v[g], 0);
            check("rst_uid", g, uid_v[g], 0);
            check("rst_uid_valid", g, uidv_v[g], 0);
            check("rst_err_sig", g, es_v[g], 0);
            check("rst_err_hex", g, eh_v[g], 0);
            check("rst_err_timeout", g, et_v[g], 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        rom_ready = 1'b1;
        load_rom(8'h4e, "0123456789ABCDEF");
        repeat (3) tick();
        check_reset_all();
        reset = 1'b0;
        tick();

        // Clean image; instance 1 expects gencode 0x41 and must flag the 'N' header.
        run_read(400);
        check("lit_uid_case1", 0, uid_v[0], 64'h0123456789ABCDEF);
        check("lit_uid_valid_case1", 0, uidv_v[0], 1);
        check("lit_gencode_case1", 0, gen_v[0], 8'h4e);
        check("lit_err_sig_case2", 1, es_v[1], 1);
        check("lit_uid_valid_case2", 1, uidv_v[1], 0);
        check("lit_uid_nostream", 2, uid_v[2], 64'h0123456789ABCDEF);

        // Non-hex 'g' at byte 14, lowercase digits elsewhere.
        load_rom(8'h4e, "0123g56789abcdef");
        run_read(400);
        check("lit_err_hex_case3", 0, eh_v[0], 1);
        check("lit_uid_nibble_case3", 0, 64'(uid_v[0][47:44]), 0);
        check("lit_uid_case3", 0, uid_v[0], 64'h0123056789ABCDEF);
        check("lit_uid_valid_case3", 0, uidv_v[0], 0);

        // ROM never ready: timeout after 16 WAITRDY clocks, nothing streamed.
        load_rom(8'h4e, "0123456789ABCDEF");
        rom_ready = 1'b0;
        run_read(100);
        check("lit_err_timeout_case4", 0, et_v[0], 1);
        check("lit_uid_valid_case4", 0, uidv_v[0], 0);
        rom_ready = 1'b1;

        // Random backpressure on the stream.
        bp_mode = 1'b1;
        chk_lat = 1'b0;
        run_read(2000);
        bp_mode = 1'b0;
        chk_lat = 1'b1;
        check("lit_uid_case5", 0, uid_v[0], 64'h0123456789ABCDEF);

        // Reset in the middle of byte 12, then a clean read with stray start pulses.
        compute_model();
        pulse_start();
        n = 0;
        while (addr_v[0] != 5'd12 && n < 100) begin
            tick();
            n++;
        end
        check("reach_byte12", 0, addr_v[0], 12);
        reset = 1'b1;
        tick();
        tick();
        check_reset_all();
        reset = 1'b0;
        tick();
        for (int g = 0; g < N; g++) ndone[g] = 0;
        compute_model();
        pulse_start();
        repeat (4) tick();
        repeat (4) begin
            pulse_start();
            tick();
        end
        wait_idle(400);
        for (int g = 0; g < N; g++) check("done_count", g, ndone[g], 1);
        check("lit_uid_case6", 0, uid_v[0], 64'h0123456789ABCDEF);
        check("lit_uid_valid_case6", 0, uidv_v[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
